// File: rtl/fetch_pc_select_pkg.sv
// Shared pipeline definitions: icode constants, fetch FSM states and PC types.
package fetch_pc_select_pkg;

  typedef logic [63:0] addr_t;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    SRC_PRED    = 2'd0,
    SRC_MISPRED = 2'd1,
    SRC_RET     = 2'd2
  } pc_src_t;

endpackage

// File: rtl/fetch_pc_select_if.sv
// Instruction-memory request/ready handshake between fetch and imem.
interface fetch_pc_select_if;
  import fetch_pc_select_pkg::*;

  logic  req;
  addr_t addr;
  logic  ready;

  modport master (output req, output addr, input ready);
  modport slave  (input req, input addr, output ready);
endinterface

// File: rtl/fetch_pc_select_pc_select_mux.sv
// Combinational redirect priority: mispredicted jump, then ret, then prediction.
module pc_select_mux
  import fetch_pc_select_pkg::*;
(
  input  logic [3:0] m_icode,
  input  logic       m_cnd,
  input  addr_t      m_vala,
  input  logic [3:0] w_icode,
  input  addr_t      w_valm,
  input  addr_t      pred_pc,
  output addr_t      sel_pc,
  output logic       redirect,
  output pc_src_t    src
);

  always_comb begin
    sel_pc   = pred_pc;
    redirect = 1'b0;
    src      = SRC_PRED;
    if (m_icode == ICODE_JXX && !m_cnd) begin
      sel_pc   = m_vala;
      redirect = 1'b1;
      src      = SRC_MISPRED;
    end else if (w_icode == ICODE_RET) begin
      sel_pc   = w_valm;
      redirect = 1'b1;
      src      = SRC_RET;
    end
  end

endmodule

// File: rtl/fetch_pc_select.sv
// Y86 fetch front end: F register, fetch PC selection and imem handshake.
// Optional performance counters are compiled in with PERF_CNT_EN.
module fetch_pc_select
  import fetch_pc_select_pkg::*;
#(
  parameter addr_t       RESET_PC = 64'h0,
  parameter int unsigned PERF_W   = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               F_stall,
  input  addr_t              pred_pc,
  input  logic [3:0]         M_icode,
  input  logic               M_cnd,
  input  addr_t              M_valA,
  input  logic [3:0]         W_icode,
  input  addr_t              W_valM,
  input  logic               f_halt,
  fetch_pc_select_if.master  imem,
  output addr_t              f_pc,
  output logic               f_pc_valid,
  output logic               f_fetch_wait
`ifdef PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]  mispredict_cnt,
  output logic [PERF_W-1:0]  ret_cnt
`endif
);

  fetch_state_t state, state_nxt;
  addr_t        f_predpc, f_predpc_nxt;
  addr_t        hold_addr, hold_nxt;
  addr_t        pend_pc, pend_nxt;
  logic         pend_valid, pend_valid_nxt;
  addr_t        sel_pc, cur_addr;
  logic         redirect, req, pc_valid;
  pc_src_t      src;

  pc_select_mux u_mux (
    .m_icode  (M_icode),
    .m_cnd    (M_cnd),
    .m_vala   (M_valA),
    .w_icode  (W_icode),
    .w_valm   (W_valM),
    .pred_pc  (f_predpc),
    .sel_pc   (sel_pc),
    .redirect (redirect),
    .src      (src)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= FETCH;
      f_predpc   <= RESET_PC;
      hold_addr  <= RESET_PC;
      pend_pc    <= RESET_PC;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      f_predpc   <= f_predpc_nxt;
      hold_addr  <= hold_nxt;
      pend_pc    <= pend_nxt;
      pend_valid <= pend_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    f_predpc_nxt   = f_predpc;
    hold_nxt       = hold_addr;
    pend_nxt       = pend_pc;
    pend_valid_nxt = pend_valid;
    req            = 1'b0;
    pc_valid       = 1'b0;
    cur_addr       = f_predpc;
    case (state)
      FETCH: begin
        req      = 1'b1;
        cur_addr = sel_pc;
        if (imem.ready) begin
          pc_valid = 1'b1;
          if (!F_stall) f_predpc_nxt = pred_pc;
          if (f_halt && !F_stall && src == SRC_PRED) state_nxt = HALTED;
        end else begin
          hold_nxt  = sel_pc;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        req      = 1'b1;
        cur_addr = hold_addr;
        if (imem.ready) begin
          state_nxt = FETCH;
          // a redirect landing in the same cycle as ready still kills the bytes
          if (pend_valid || redirect) begin
            f_predpc_nxt   = redirect ? sel_pc : pend_pc;
            pend_valid_nxt = 1'b0;
          end else begin
            pc_valid = 1'b1;
            if (!F_stall) f_predpc_nxt = pred_pc;
            if (f_halt && !F_stall) state_nxt = HALTED;
          end
        end else if (redirect) begin
          pend_valid_nxt = 1'b1;
          pend_nxt       = sel_pc;
        end
      end
      HALTED: begin
        if (redirect) begin
          f_predpc_nxt = sel_pc;
          state_nxt    = FETCH;
        end
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Outputs are forced to their reset values for as long as reset is held.
  assign imem.req     = reset_n & req;
  assign imem.addr    = reset_n ? cur_addr : RESET_PC;
  assign f_pc         = reset_n ? cur_addr : RESET_PC;
  assign f_pc_valid   = reset_n & pc_valid;
  assign f_fetch_wait = imem.req & ~imem.ready;

`ifdef PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mispredict_cnt <= '0;
      ret_cnt        <= '0;
    end else begin
      if (src == SRC_MISPRED) mispredict_cnt <= mispredict_cnt + 1'b1;
      if (src == SRC_RET)     ret_cnt        <= ret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_select.sv
// Directed, table-driven bench for fetch_pc_select with RESET_PC=0x100.
module tb_fetch_pc_select;
  import fetch_pc_select_pkg::*;

  localparam addr_t RST_PC = 64'h100;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       F_stall = 1'b0;
  addr_t      pred_pc = '0;
  logic [3:0] M_icode = 4'h1;
  logic       M_cnd = 1'b1;
  addr_t      M_valA = '0;
  logic [3:0] W_icode = 4'h1;
  addr_t      W_valM = '0;
  logic       f_halt = 1'b0;
  addr_t      f_pc;
  logic       f_pc_valid, f_fetch_wait;
`ifdef PERF_CNT_EN
  logic [31:0] mispredict_cnt, ret_cnt;
`endif

  fetch_pc_select_if imem ();

  fetch_pc_select #(.RESET_PC(RST_PC), .PERF_W(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .F_stall      (F_stall),
    .pred_pc      (pred_pc),
    .M_icode      (M_icode),
    .M_cnd        (M_cnd),
    .M_valA       (M_valA),
    .W_icode      (W_icode),
    .W_valM       (W_valM),
    .f_halt       (f_halt),
    .imem         (imem),
    .f_pc         (f_pc),
    .f_pc_valid   (f_pc_valid),
    .f_fetch_wait (f_fetch_wait)
`ifdef PERF_CNT_EN
    ,
    .mispredict_cnt (mispredict_cnt),
    .ret_cnt        (ret_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ready;
    logic       stall;
    addr_t      pred;
    logic [3:0] mi;
    logic       mc;
    addr_t      mva;
    logic [3:0] wi;
    addr_t      wvm;
    logic       halt;
    logic       e_req;
    addr_t      e_addr;
    logic       chk_addr;
    logic       e_valid;
    logic       e_wait;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[26];

  function automatic vec_t v(logic r, logic s, addr_t p, logic [3:0] mi, logic mc, addr_t mva,
                             logic [3:0] wi, addr_t wvm, logic h,
                             logic er, addr_t ea, logic ca, logic ev, logic ew);
    vec_t t;
    t.ready = r; t.stall = s; t.pred = p; t.mi = mi; t.mc = mc; t.mva = mva;
    t.wi = wi; t.wvm = wvm; t.halt = h;
    t.e_req = er; t.e_addr = ea; t.chk_addr = ca; t.e_valid = ev; t.e_wait = ew;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic er, input addr_t ea, input logic ca,
                          input logic ev, input logic ew);
    chk({tag, ".req"}, {63'd0, imem.req}, {63'd0, er});
    if (ca) begin
      chk({tag, ".imem_addr"}, imem.addr, ea);
      chk({tag, ".f_pc"}, f_pc, ea);
    end
    chk({tag, ".valid"}, {63'd0, f_pc_valid}, {63'd0, ev});
    chk({tag, ".wait"}, {63'd0, f_fetch_wait}, {63'd0, ew});
  endtask

  initial begin
    //           rdy stl pred      mi mc mva      wi wvm      h   req addr     ca vld wt
    vecs[0]  = v(1, 0, 64'h10A, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h100, 1, 1, 0);
    vecs[1]  = v(1, 0, 64'h114, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h10A, 1, 1, 0);
    vecs[2]  = v(1, 0, 64'h209, 7, 0, 64'h200, 9, 64'h300, 0,  1, 64'h200, 1, 1, 0);
    vecs[3]  = v(1, 0, 64'h140, 1, 1, 64'h0,   9, 64'h300, 0,  1, 64'h300, 1, 1, 0);
    vecs[4]  = v(0, 0, 64'h14A, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h140, 1, 0, 1);
    vecs[5]  = v(0, 0, 64'h999, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h140, 1, 0, 1);
    vecs[6]  = v(0, 0, 64'h888, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h140, 1, 0, 1);
    vecs[7]  = v(1, 0, 64'h14A, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h140, 1, 1, 0);
    vecs[8]  = v(1, 0, 64'h154, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h14A, 1, 1, 0);
    vecs[9]  = v(0, 0, 64'h777, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h154, 1, 0, 1);
    vecs[10] = v(0, 0, 64'h666, 1, 1, 64'h0,   9, 64'h300, 0,  1, 64'h154, 1, 0, 1);
    vecs[11] = v(1, 0, 64'h555, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h154, 1, 0, 0);
    vecs[12] = v(1, 0, 64'h301, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h300, 1, 1, 0);
    vecs[13] = v(1, 0, 64'h302, 1, 1, 64'h0,   1, 64'h0,   1,  1, 64'h301, 1, 1, 0);
    vecs[14] = v(1, 0, 64'h444, 1, 1, 64'h0,   1, 64'h0,   0,  0, 64'h0,   0, 0, 0);
    vecs[15] = v(0, 0, 64'h444, 1, 1, 64'h0,   1, 64'h0,   0,  0, 64'h0,   0, 0, 0);
    vecs[16] = v(1, 0, 64'h444, 7, 0, 64'h180, 1, 64'h0,   0,  0, 64'h0,   0, 0, 0);
    vecs[17] = v(1, 0, 64'h18A, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h180, 1, 1, 0);
    vecs[18] = v(1, 1, 64'h194, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h18A, 1, 1, 0);
    vecs[19] = v(1, 1, 64'h19E, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h18A, 1, 1, 0);
    vecs[20] = v(1, 0, 64'h194, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h18A, 1, 1, 0);
    vecs[21] = v(1, 0, 64'h1A0, 7, 1, 64'h333, 1, 64'h0,   0,  1, 64'h194, 1, 1, 0);
    vecs[22] = v(1, 1, 64'h222, 7, 0, 64'h250, 1, 64'h0,   0,  1, 64'h250, 1, 1, 0);
    vecs[23] = v(1, 0, 64'h1AA, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h1A0, 1, 1, 0);
    vecs[24] = v(1, 1, 64'h222, 1, 1, 64'h0,   1, 64'h0,   1,  1, 64'h1AA, 1, 1, 0);
    vecs[25] = v(1, 0, 64'h1B4, 1, 1, 64'h0,   1, 64'h0,   0,  1, 64'h1AA, 1, 1, 0);

    imem.ready = 1'b0;
    #2;
    chk_outs("reset", 1'b0, RST_PC, 1'b1, 1'b0, 1'b0);
`ifdef PERF_CNT_EN
    chk("reset.mispredict_cnt", {32'd0, mispredict_cnt}, 64'd0);
    chk("reset.ret_cnt", {32'd0, ret_cnt}, 64'd0);
`endif

    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      imem.ready = vecs[i].ready;
      F_stall    = vecs[i].stall;
      pred_pc    = vecs[i].pred;
      M_icode    = vecs[i].mi;
      M_cnd      = vecs[i].mc;
      M_valA     = vecs[i].mva;
      W_icode    = vecs[i].wi;
      W_valM     = vecs[i].wvm;
      f_halt     = vecs[i].halt;
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].chk_addr,
               vecs[i].e_valid, vecs[i].e_wait);
      @(negedge clock);
    end

`ifdef PERF_CNT_EN
    chk("mispredict_cnt", {32'd0, mispredict_cnt}, 64'd3);
    chk("ret_cnt", {32'd0, ret_cnt}, 64'd2);
`endif

    // Reset pulsed while a request is outstanding.
    imem.ready = 1'b0;
    F_stall = 1'b0; f_halt = 1'b0;
    M_icode = 4'h1; M_cnd = 1'b1; W_icode = 4'h1;
    pred_pc = 64'h5A5;
    #1;
    chk_outs("rstwait.enter", 1'b1, 64'h1B4, 1'b1, 1'b0, 1'b1);
    @(negedge clock);
    #1;
    chk_outs("rstwait.hold", 1'b1, 64'h1B4, 1'b1, 1'b0, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk_outs("rstwait.async", 1'b0, RST_PC, 1'b1, 1'b0, 1'b0);
`ifdef PERF_CNT_EN
    chk("rstwait.mispredict_cnt", {32'd0, mispredict_cnt}, 64'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;
    imem.ready = 1'b1;
    pred_pc = 64'h10A;
    #1;
    chk_outs("rstwait.restart", 1'b1, RST_PC, 1'b1, 1'b1, 1'b0);
    @(negedge clock);
    #1;
    chk_outs("rstwait.next", 1'b1, 64'h10A, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
